// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load and a bit-rate strobe.
// Frames are sent back-to-back with no idle bit when the next word is waiting.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_first,
    output logic             frame_last
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic              serial_out_q, serial_out_d;
    logic              serial_valid_q, serial_valid_d;
    logic              frame_first_q, frame_first_d;
    logic              frame_last_q, frame_last_d;

    logic              last_bit;
    logic              accept;
    logic [WIDTH-1:0]  shifted;

    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        bitcnt_d       = bitcnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        frame_first_d  = frame_first_q;
        frame_last_d   = frame_last_q;

        last_bit   = (state_q == StShift) && (bitcnt_q == CntW'(WIDTH - 1));
        load_ready = (state_q == StIdle) || (last_bit && shift_en);
        accept     = load_valid && load_ready;

        // The bit on the line always sits at the output end of sreg.
        if (MSB_FIRST != 0) begin
            shifted = sreg_q << 1;
        end else begin
            shifted = sreg_q >> 1;
        end

        if (accept) begin
            state_d        = StShift;
            sreg_d         = load_data;
            bitcnt_d       = '0;
            serial_out_d   = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
            serial_valid_d = 1'b1;
            frame_first_d  = 1'b1;
            frame_last_d   = 1'b0;
        end else if (state_q == StShift && shift_en) begin
            if (last_bit) begin
                state_d        = StIdle;
                bitcnt_d       = '0;
                serial_out_d   = 1'b0;
                serial_valid_d = 1'b0;
                frame_first_d  = 1'b0;
                frame_last_d   = 1'b0;
            end else begin
                bitcnt_d      = bitcnt_q + 1'b1;
                sreg_d        = shifted;
                serial_out_d  = (MSB_FIRST != 0) ? shifted[WIDTH-1] : shifted[0];
                frame_first_d = 1'b0;
                frame_last_d  = (bitcnt_q == CntW'(WIDTH - 2));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            sreg_q         <= '0;
            bitcnt_q       <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_first_q  <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            bitcnt_q       <= bitcnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_first_q  <= frame_first_d;
            frame_last_q   <= frame_last_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_first  = frame_first_q;
    assign frame_last   = frame_last_q;

endmodule
